// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stop/no-stop levels,
// the four stall vectors (bit0 PC .. bit5 WB, 1 = stop) and the multi-cycle
// sequencer state encoding.
package pipe_stall_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_e;

    // Fixed-priority merge of the stall requests; the first active source wins.
    function automatic logic [5:0] stall_sel(input logic req_mem,
                                             input logic req_ex,
                                             input logic req_id);
        logic [5:0] v;
        v = STALL_NONE;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        return v;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
// master = pipeline side (raises requests), slave = controller.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
);

    logic              stallreq_id;
    logic              stallreq_mem;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              mc_abort;
    logic [5:0]        stall;
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  mc_remain;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_mem, mc_start, mc_cycles, mc_abort,
        input  stall, mc_busy, mc_done, mc_remain, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_mem, mc_start, mc_cycles, mc_abort,
        output stall, mc_busy, mc_done, mc_remain, stall_cycles
    );

endinterface

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: holds an instruction in EX for N cycles (start
// cycle included), then reports completion in DONE, lingering there while
// MEM is stalled. Synchronous active-low reset, mc_abort returns to IDLE.
module pipe_stall_ctrl_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             mc_start_i,
    input  logic [CNT_W-1:0] mc_cycles_i,
    input  logic             mc_abort_i,
    input  logic             stallreq_mem_i,
    output logic             stallreq_ex_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] mc_remain_o
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] remain_q;
    logic             start_ok;

    assign start_ok = mc_start_i && (mc_cycles_i != '0);

    // Next-state and hold counter; the counter holds the BUSY cycles still to come.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mc_abort_i) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (start_ok) begin
                        cnt_d   = mc_cycles_i - CNT_W'(1);
                        state_d = (mc_cycles_i == CNT_W'(1)) ? MC_DONE : MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = MC_DONE;
                    end
                end
                MC_DONE: begin
                    if (!stallreq_mem_i) begin
                        state_d = MC_IDLE;
                    end
                end
                default: begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered status outputs; status is derived from
    // the next state so it lines up with state_q in the same cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= MC_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == MC_BUSY);
            done_q   <= (state_d == MC_DONE);
            remain_q <= (state_d == MC_BUSY) ? cnt_d : '0;
        end
    end

    // EX stall is raised already in the accepting IDLE cycle; all outputs
    // are forced low while reset is held.
    assign stallreq_ex_o = (Rst_n && ((state_q == MC_BUSY) ||
                                      ((state_q == MC_IDLE) && start_ok))) ? STOP : NOSTOP;
    assign mc_busy_o     = Rst_n && busy_q;
    assign mc_done_o     = Rst_n && done_q;
    assign mc_remain_o   = Rst_n ? remain_q : '0;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall control: merges MEM, EX (multi-cycle sequencer) and
// ID stall requests by priority into the 6-bit stall vector.
// Optional stall-cycle performance counter: define PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic           Clk,
    input  logic           Rst_n,
    pipe_stall_ctrl_if.slave bus
);

    logic       stallreq_ex;
    logic [5:0] stall_vec;

    pipe_stall_ctrl_mc_seq #(
        .CNT_W (CNT_W)
    ) u_mc_seq (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .mc_start_i     (bus.mc_start),
        .mc_cycles_i    (bus.mc_cycles),
        .mc_abort_i     (bus.mc_abort),
        .stallreq_mem_i (bus.stallreq_mem),
        .stallreq_ex_o  (stallreq_ex),
        .mc_busy_o      (bus.mc_busy),
        .mc_done_o      (bus.mc_done),
        .mc_remain_o    (bus.mc_remain)
    );

    // Priority merge; ID-only stall freezes PC/IF/ID so ID/EX takes a bubble.
    always_comb begin
        stall_vec = STALL_NONE;
        if (Rst_n) begin
            stall_vec = stall_sel(bus.stallreq_mem, stallreq_ex, bus.stallreq_id);
        end
    end

    assign bus.stall = stall_vec;

`ifdef PIPE_STALL_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Saturating count of cycles with any stage stopped.
    always_comb begin
        perf_d = perf_q;
        if ((stall_vec != STALL_NONE) && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // Performance counter register, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.stall_cycles = perf_q;
`else
    assign bus.stall_cycles = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random traffic, checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int unsigned CNT_W = 6;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 Clk = ~Clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(32)) bus ();

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

`ifdef PIPE_STALL_PERF_EN
    pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(4)) bus4 ();

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(4)) dut4 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus4)
    );

    assign bus4.stallreq_id  = bus.stallreq_id;
    assign bus4.stallreq_mem = bus.stallreq_mem;
    assign bus4.mc_start     = bus.mc_start;
    assign bus4.mc_cycles    = bus.mc_cycles;
    assign bus4.mc_abort     = bus.mc_abort;
`endif

    int total = 0;
    int bad   = 0;

    // Model: ex_left = EX hold cycles still owed after the accepting cycle,
    // done_pend = result is being presented to EX.
    int          ex_left   = 0;
    bit          done_pend = 1'b0;
    longint      perf_cnt  = 0;
    int          perf_cnt4 = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic run_cycle(input bit rst_n, input bit id, input bit mem,
                             input bit start, input int n, input bit abort);
        logic [5:0] exp_stall;
        bit         ex_req;
        @(negedge Clk);
        Rst_n            = rst_n;
        bus.stallreq_id  = id;
        bus.stallreq_mem = mem;
        bus.mc_start     = start;
        bus.mc_cycles    = CNT_W'(n);
        bus.mc_abort     = abort;
        #1;
        exp_stall = 6'b000000;
        if (rst_n) begin
            ex_req = (ex_left > 0) || (!done_pend && start && (n != 0));
            if (mem)         exp_stall = 6'b011111;
            else if (ex_req) exp_stall = 6'b001111;
            else if (id)     exp_stall = 6'b000111;
        end
        check_val("stall",     32'(bus.stall),     32'(exp_stall));
        check_val("mc_busy",   32'(bus.mc_busy),   32'(rst_n && (ex_left > 0)));
        check_val("mc_done",   32'(bus.mc_done),   32'(rst_n && done_pend));
        check_val("mc_remain", 32'(bus.mc_remain), rst_n ? 32'(ex_left) : 32'd0);
`ifdef PIPE_STALL_PERF_EN
        check_val("stall_cycles",   bus.stall_cycles,        32'(perf_cnt));
        check_val("stall_cycles_4", 32'(bus4.stall_cycles), 32'(perf_cnt4));
`else
        check_val("stall_cycles",   bus.stall_cycles,        32'd0);
`endif
        @(posedge Clk);
        if (!rst_n) begin
            ex_left   = 0;
            done_pend = 1'b0;
            perf_cnt  = 0;
            perf_cnt4 = 0;
        end else begin
            if (exp_stall != 6'b000000) begin
                if (perf_cnt < 64'hFFFF_FFFF) perf_cnt++;
                if (perf_cnt4 < 15) perf_cnt4++;
            end
            if (abort) begin
                ex_left   = 0;
                done_pend = 1'b0;
            end else if (ex_left > 0) begin
                ex_left--;
                if (ex_left == 0) done_pend = 1'b1;
            end else if (done_pend) begin
                done_pend = mem;
            end else if (start && (n != 0)) begin
                ex_left   = n - 1;
                done_pend = (n == 1);
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bus.stallreq_id  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.mc_start     = 1'b0;
        bus.mc_cycles    = '0;
        bus.mc_abort     = 1'b0;

        // Reset with active requests: outputs stay quiet.
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b0);
        idle(2);

        // Priority ladder, ending with an N=4 op accepted under a MEM stall.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0);
        idle(6);

        // N=3, N=1, N=0.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle(4);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle(3);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // N=2 with MEM wait during DONE; mc_start during BUSY/DONE is ignored.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        idle(3);

        // Abort in cycle 4 of an N=10 op, then an immediate new op.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        idle(3);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        idle(4);

        // Perf scenario from a clean reset: 5 ID stalls plus an N=3 op.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rn, id, mem, st, ab;
            int n;
            rn  = ($urandom_range(0, 199) != 0);
            id  = ($urandom_range(0, 3) == 0);
            mem = ($urandom_range(0, 4) == 0);
            st  = ($urandom_range(0, 2) == 0);
            ab  = ($urandom_range(0, 39) == 0);
            n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 6));
            run_cycle(rn, id, mem, st, n, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
